// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
//   Bank of NUM_EVENTS independent event counters with per-channel clear,
//   sticky overflow flags, an atomic snapshot into shadow registers and a
//   registered readback port for the shadows.
//
// Ports
//   clk          : single clock; all state updates on its rising edge
//   rst          : synchronous, active-low reset
//   event_in     : per-channel increment strobes (bit i -> counter i)
//   halt         : suppresses every increment (clear/snap/readback unaffected)
//   clr_vec      : per-channel clear of counter and overflow flag
//   snap         : copy all live counters (pre-update values) into the shadows
//   rd_idx       : shadow channel select for readback
//   rd_data      : shadow[rd_idx], one cycle latency; 0 when rd_idx is out of range
//   snap_done    : one-cycle pulse in the cycle after snap was sampled
//   ovf          : sticky per-channel overflow flags
//   counts_flat  : live counters, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
// -----------------------------------------------------------------------------
module perf_counter_bank #(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_WIDTH  = 32,
    parameter int SATURATE   = 0,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_EVENTS-1:0]            event_in,
    input  logic                             halt,
    input  logic [NUM_EVENTS-1:0]            clr_vec,
    input  logic                             snap,
    input  logic [IDX_WIDTH-1:0]             rd_idx,
    output logic [CNT_WIDTH-1:0]             rd_data,
    output logic                             snap_done,
    output logic [NUM_EVENTS-1:0]            ovf,
    output logic [NUM_EVENTS*CNT_WIDTH-1:0]  counts_flat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0]  cnt      [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]  shadow   [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]  cnt_nxt  [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] ovf_nxt;
    logic [CNT_WIDTH-1:0]  rd_mux;

    // Next-state of each counter and its overflow flag. Clear wins over an
    // increment in the same cycle, so a coincident overflow leaves ovf at 0.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        ovf_nxt = ovf;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (clr_vec[i]) begin
                cnt_nxt[i] = '0;
                ovf_nxt[i] = 1'b0;
            end else if (event_in[i] && !halt) begin
                if (cnt[i] == CNT_MAX) begin
                    ovf_nxt[i] = 1'b1;
                    cnt_nxt[i] = (SATURATE != 0) ? CNT_MAX : '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Readback select over the current shadows. Out-of-range indices return 0
    // rather than aliasing onto a real channel.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd_idx == IDX_WIDTH'(i)) begin
                rd_mux = shadow[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; this is what makes the snapshot capture the counter
    // value from before this cycle's increment or clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the shadow array is reset along with the counters because
            // software may read a shadow before the first snapshot and must
            // see 0, not power-up garbage.
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
            ovf       <= '0;
            rd_data   <= '0;
            snap_done <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                cnt[i] <= cnt_nxt[i];
                if (snap) begin
                    shadow[i] <= cnt[i];
                end
            end
            ovf       <= ovf_nxt;
            // rd_mux sees the shadows before this edge, so a snap in the same
            // cycle shows up on rd_data one cycle later.
            rd_data   <= rd_mux;
            snap_done <= snap;
        end
    end

    always_comb begin
        counts_flat = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            counts_flat[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
        end
    end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 The block SHALL have parameter NUM_EVENTS, default 6, number of independent event counter channels (1..16).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32, bit width of every counter and shadow register (4..64).
REQ-003 The block SHALL have parameter SATURATE, default 0, where 0 means counters wrap and 1 means counters saturate.
REQ-004 The block SHALL have parameter IDX_WIDTH, default 4, width of the read index.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port event_in, input, NUM_EVENTS bits: per-channel increment strobes, with bit i incrementing counter i.
REQ-008 The block SHALL have port halt, input, 1 bit: CPU halted (syscall stop); suppresses all increments.
REQ-009 The block SHALL have port clr_vec, input, NUM_EVENTS bits: per-channel synchronous clear.
REQ-010 The block SHALL have port snap, input, 1 bit: snapshot request; copies all live counters into shadow registers.
REQ-011 The block SHALL have port rd_idx, input, IDX_WIDTH bits: shadow channel select for readback.
REQ-012 The block SHALL have port rd_data, output, CNT_WIDTH bits: registered shadow value of the channel selected by rd_idx.
REQ-013 The block SHALL have port snap_done, output, 1 bit: one-cycle pulse, asserted the cycle after the shadows are loaded.
REQ-014 The block SHALL have port ovf, output, NUM_EVENTS bits: sticky per-channel overflow flags.
REQ-015 The block SHALL have port counts_flat, output, NUM_EVENTS*CNT_WIDTH bits: live counters, with channel i at bits [i*CNT_WIDTH +: CNT_WIDTH].

Function
REQ-016 Per cycle, channel i SHALL increment by exactly 1 when event_in[i]=1, halt=0 and clr_vec[i]=0; otherwise it SHALL hold.
REQ-017 When clr_vec[i]=1, counter i and ovf[i] SHALL become 0 next cycle, overriding any same-cycle increment; the event is lost.
REQ-018 With SATURATE=0, an increment at all-ones SHALL wrap the counter to 0 and set ovf[i].
REQ-019 With SATURATE=1, an increment at all-ones SHALL hold all-ones and set ovf[i]; further increments SHALL keep all-ones.
REQ-020 ovf[i] SHALL remain set until clr_vec[i] or reset; a same-cycle overflow and clear SHALL result in ovf[i]=0.
REQ-021 On snap=1, every shadow i SHALL load the live counter value present before that cycle's increment or clear (pre-update value), all channels atomically.
REQ-022 snap_done SHALL be 1 in the cycle after snap was sampled high and 0 otherwise; back-to-back snap cycles SHALL produce back-to-back snap_done pulses.
REQ-023 rd_data SHALL equal shadow[rd_idx] registered with one cycle latency; when rd_idx >= NUM_EVENTS, rd_data SHALL be 0.
REQ-024 When rd_idx targets the channel loaded by snap in the same cycle, rd_data SHALL show the pre-snap shadow value; the new value SHALL appear one cycle later.
REQ-025 halt SHALL NOT block clr_vec, snap or readback.
REQ-026 counts_flat SHALL reflect the registered live counters with no combinational path from event_in.

Reset
REQ-027 While rst=0 at a clock edge, all counters, shadows, ovf, rd_data and snap_done SHALL become 0.
REQ-028 Reset SHALL override all other inputs in the same cycle; a snap or event coincident with reset SHALL have no effect.
REQ-029 Reset asserted mid-count SHALL discard all accumulated values; counting SHALL resume from 0 on the first cycle with rst=1.

Verification
REQ-030 The bench SHALL cover basic counting: drive event_in[0]=1 for 10 cycles with halt=0, then snap, then rd_idx=0 -> rd_data=10 two cycles after snap and snap_done pulsed once.
REQ-031 The bench SHALL cover wrap: CNT_WIDTH=4 and SATURATE=0, drive 17 events on channel 2 -> counter 2=1 and ovf[2]=1; then clr_vec[2] -> counter=0 and ovf[2]=0.
REQ-032 The bench SHALL cover saturate: CNT_WIDTH=4 and SATURATE=1, drive 20 events on channel 1 -> counter 1=15 and ovf[1]=1 held.
REQ-033 The bench SHALL cover halt: with channel 3 at 5, drive halt=1 with event_in[3]=1 for 4 cycles -> counter 3 stays 5, and snap still loads shadow 3=5.
REQ-034 The bench SHALL cover simultaneous events: with counter 0=7, drive event_in[0], clr_vec[0] and snap in one cycle -> counter 0=0 and shadow 0=7.
REQ-035 The bench SHALL cover reset and out-of-range read: drive rst=0 for one cycle mid-count -> all outputs 0; then rd_idx=15 with NUM_EVENTS=6 -> rd_data=0.
